// File: rtl/sram_ctl_pkg.sv
// rtl/sram_ctl_pkg.sv - shared widths, FSM encoding and descriptor type for the SRAM write path
package sram_ctl_pkg;

  localparam int DATA_W     = 64;
  localparam int DES_PORT_W = 4;
  localparam int PACK_LEN_W = 7;
  localparam int ADDR_W     = 11;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int MAX_PKT    = (1 << PACK_LEN_W) - 1;

  // Largest used count that still leaves room for a maximum-length packet.
  localparam logic [ADDR_W:0] USED_RDY_MAX = (ADDR_W+1)'(DEPTH - MAX_PKT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [DES_PORT_W-1:0] port;
    logic [ADDR_W-1:0]     addr;
    logic [PACK_LEN_W-1:0] len;
  } desc_t;

endpackage

// File: rtl/sram_write_ctl_space.sv
// rtl/sram_write_ctl_space.sv - sram_space_cnt: used-word accounting and registered in_rdy
module sram_space_cnt
  import sram_ctl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reserve_en,
  input  logic [PACK_LEN_W-1:0] reserve_len,
  input  logic                  excess_en,
  input  logic [PACK_LEN_W-1:0] excess_len,
  input  logic                  rel_vld,
  input  logic [PACK_LEN_W-1:0] rel_len,
  input  logic                  idle_next,
  output logic [ADDR_W:0]       used_words,
  output logic                  in_rdy,
  output logic                  underflow
);

  logic [ADDR_W:0]   used_q, used_d;
  logic              rdy_q, rdy_d;
  logic [ADDR_W+1:0] add_v, sub_v;

  // One combined update per cycle: reserve adds, excess and release subtract, floor at zero.
  always_comb begin
    add_v = (ADDR_W+2)'(used_q) + (reserve_en ? (ADDR_W+2)'(reserve_len) : '0);
    sub_v = (excess_en ? (ADDR_W+2)'(excess_len) : '0) + (rel_vld ? (ADDR_W+2)'(rel_len) : '0);
    underflow = 1'b0;
    used_d = (ADDR_W+1)'(add_v - sub_v);
    if (sub_v > add_v) begin
      used_d    = '0;
      underflow = 1'b1;
    end
    rdy_d = idle_next && (used_d <= USED_RDY_MAX);
  end

  // Counter and ready flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      used_q <= used_d;
      rdy_q  <= rdy_d;
    end
  end

  assign used_words = used_q;
  assign in_rdy     = rdy_q;

endmodule

// File: rtl/sram_write_ctl.sv
// rtl/sram_write_ctl.sv - packet writer into circular SRAM with descriptors; stats ports under WRITE_CTL_STATS_EN
module sram_write_ctl
  import sram_ctl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DES_PORT_W-1:0] in_des_port,
  input  logic [PACK_LEN_W-1:0] in_pack_length,
  output logic                  in_rdy,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  output logic                  desc_vld,
  output logic [DES_PORT_W-1:0] desc_port,
  output logic [ADDR_W-1:0]     desc_addr,
  output logic [PACK_LEN_W-1:0] desc_len,
  input  logic                  rel_vld,
  input  logic [PACK_LEN_W-1:0] rel_len,
  output logic [ADDR_W:0]       used_words,
  output logic                  err_len
`ifdef WRITE_CTL_STATS_EN
  ,
  output logic [15:0]           stat_pkt_cnt,
  output logic [15:0]           stat_err_cnt
`endif
);

  localparam logic [PACK_LEN_W-1:0] LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0]     ADDR_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  desc_t                 cur_q, cur_d;
  logic [PACK_LEN_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  dvld_q, dvld_d;
  desc_t                 desc_q, desc_d;
  logic                  err_q, err_d;

  logic                  commit;
  desc_t                 commit_desc;
  logic [PACK_LEN_W-1:0] commit_len;
  logic                  proto_err;
  logic                  reserve_en;
  logic                  excess_en;
  logic [PACK_LEN_W-1:0] excess_len;
  logic                  underflow;
  logic                  idle_next;

  // Packet FSM: accept, write, drain overrun words, and commit the descriptor.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    commit      = 1'b0;
    commit_desc = '{port: cur_q.port, addr: cur_q.addr, len: cnt_q};
    commit_len  = cur_q.len;
    proto_err   = 1'b0;
    reserve_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_vld) begin
          if (!in_sop || !in_rdy) begin
            proto_err = 1'b1;
          end else if (in_pack_length == '0) begin
            proto_err = 1'b1;
            cur_d.len = '0;
            cnt_d     = '0;
            if (!in_eop) state_d = ST_DRAIN;
          end else begin
            cur_d      = '{port: in_des_port, addr: wr_ptr_q, len: in_pack_length};
            cnt_d      = LEN_ONE;
            reserve_en = 1'b1;
            we_d       = 1'b1;
            waddr_d    = wr_ptr_q;
            wdata_d    = in_data;
            wr_ptr_d   = wr_ptr_q + ADDR_ONE;
            if (in_eop) begin
              commit      = 1'b1;
              commit_desc = '{port: in_des_port, addr: wr_ptr_q, len: LEN_ONE};
              commit_len  = in_pack_length;
            end else if (in_pack_length == LEN_ONE) begin
              proto_err = 1'b1;
              state_d   = ST_DRAIN;
            end else begin
              state_d = ST_WRITE;
            end
          end
        end
      end
      ST_WRITE: begin
        if (in_vld) begin
          we_d     = 1'b1;
          waddr_d  = wr_ptr_q;
          wdata_d  = in_data;
          wr_ptr_d = wr_ptr_q + ADDR_ONE;
          cnt_d    = cnt_q + LEN_ONE;
          if (in_sop) proto_err = 1'b1;
          if (in_eop) begin
            commit           = 1'b1;
            commit_desc.len  = cnt_q + LEN_ONE;
          end else if ((cnt_q + LEN_ONE) == cur_q.len) begin
            proto_err = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (in_vld && in_eop) begin
          if (cur_q.len != '0) commit = 1'b1;
          else state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) state_d = ST_IDLE;
    excess_en  = commit && (commit_desc.len != commit_len);
    excess_len = commit_len - commit_desc.len;
    dvld_d     = commit;
    desc_d     = commit ? commit_desc : desc_q;
  end

  assign idle_next = (state_d == ST_IDLE);
  assign err_d     = proto_err | excess_en | underflow;

  sram_space_cnt u_space (
    .clk         (clk),
    .rst         (rst),
    .reserve_en  (reserve_en),
    .reserve_len (in_pack_length),
    .excess_en   (excess_en),
    .excess_len  (excess_len),
    .rel_vld     (rel_vld),
    .rel_len     (rel_len),
    .idle_next   (idle_next),
    .used_words  (used_words),
    .in_rdy      (in_rdy),
    .underflow   (underflow)
  );

  // Control state and registered SRAM/descriptor/error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      dvld_q   <= 1'b0;
      desc_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      dvld_q   <= dvld_d;
      desc_q   <= desc_d;
      err_q    <= err_d;
    end
  end

  assign sram_we    = we_q;
  assign sram_addr  = waddr_q;
  assign sram_wdata = wdata_q;
  assign desc_vld   = dvld_q;
  assign desc_port  = desc_q.port;
  assign desc_addr  = desc_q.addr;
  assign desc_len   = desc_q.len;
  assign err_len    = err_q;

`ifdef WRITE_CTL_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Wrapping event counters for committed descriptors and error pulses.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q + {15'd0, dvld_d};
    err_cnt_d = err_cnt_q + {15'd0, err_d};
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stat_pkt_cnt = pkt_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sram_write_ctl.sv
// tb/tb_sram_write_ctl.sv - self-checking bench for sram_write_ctl
module tb_sram_write_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld, in_sop, in_eop;
  logic [63:0] in_data;
  logic [3:0]  in_des_port;
  logic [6:0]  in_pack_length;
  logic        in_rdy;
  logic        sram_we;
  logic [10:0] sram_addr;
  logic [63:0] sram_wdata;
  logic        desc_vld;
  logic [3:0]  desc_port;
  logic [10:0] desc_addr;
  logic [6:0]  desc_len;
  logic        rel_vld;
  logic [6:0]  rel_len;
  logic [11:0] used_words;
  logic        err_len;
`ifdef WRITE_CTL_STATS_EN
  logic [15:0] stat_pkt_cnt, stat_err_cnt;
`endif

  sram_write_ctl dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_des_port(in_des_port), .in_pack_length(in_pack_length),
    .in_rdy(in_rdy), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .desc_vld(desc_vld), .desc_port(desc_port), .desc_addr(desc_addr), .desc_len(desc_len),
    .rel_vld(rel_vld), .rel_len(rel_len), .used_words(used_words), .err_len(err_len)
`ifdef WRITE_CTL_STATS_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [63:0] data; int stamp; } wr_t;
  typedef struct { int port; int addr; int len; int stamp; } dsc_t;
  typedef struct { int port; int decl; int act; int exp_desc; int exp_dlen; int exp_err; int exp_used; } vec_t;

  wr_t  wq[$];
  dsc_t dq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_wr_ptr = 0;
  int   m_used = 0;
  int   exp_err = 0;
  int   err_seen = 0;
  int   desc_cnt = 0;
  int   last_desc_len, last_desc_addr, last_desc_port;
  logic desc_we_seen;
  int   desc_waddr_seen;
  int   used_after_sop;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write and descriptor must match the model, in order and at the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_we) begin
        if (wq.size() == 0) chk(1'b0, "unexpected_write", 64'(sram_addr), 64'hffff);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk(sram_addr == e.addr[10:0] && sram_wdata == e.data && cyc == e.stamp,
              "write", {32'(cyc), 21'd0, sram_addr}, {32'(e.stamp), 21'd0, e.addr[10:0]});
        end
      end
      if (desc_vld) begin
        desc_cnt++;
        last_desc_len   = int'(desc_len);
        last_desc_addr  = int'(desc_addr);
        last_desc_port  = int'(desc_port);
        desc_we_seen    = sram_we;
        desc_waddr_seen = int'(sram_addr);
        if (dq.size() == 0) chk(1'b0, "unexpected_desc", 64'(desc_addr), 64'hffff);
        else begin
          dsc_t d;
          d = dq.pop_front();
          chk(desc_port == d.port[3:0] && desc_addr == d.addr[10:0] && desc_len == d.len[6:0] && cyc == d.stamp,
              "desc", {desc_port, desc_addr, desc_len}, {d.port[3:0], d.addr[10:0], d.len[6:0]});
        end
      end
      if (err_len) err_seen++;
    end
  end

  task automatic maybe_rel();
    int r;
    if (($urandom % 4) == 0 && m_used > 0) begin
      r = $urandom_range(1, (m_used > 127) ? 127 : m_used);
      rel_vld = 1'b1;
      rel_len = r[6:0];
      m_used -= r;
    end
  endtask

  task automatic release_n(input int n);
    rel_vld = 1'b1;
    rel_len = n[6:0];
    m_used -= n;
    step();
    rel_vld = 1'b0;
  endtask

  task automatic release_all();
    while (m_used > 0) release_n((m_used > 127) ? 127 : m_used);
  endtask

  task automatic drive_pkt(input int port, input int decl, input int act, input bit gaps,
                           input bit rnd_rel, input int rel_first);
    int guard, base, wlen;
    guard = 0;
    while (!in_rdy && guard < 400) begin
      if (m_used > 0) release_n((m_used > 127) ? 127 : m_used);
      else step();
      guard++;
    end
    chk(in_rdy == 1'b1, "rdy_wait", 64'(in_rdy), 64'd1);
    if (!in_rdy) return;
    base = m_wr_ptr;
    wlen = (decl == 0) ? 0 : ((act < decl) ? act : decl);
    for (int i = 0; i < act; i++) begin
      if (gaps) begin
        while (($urandom % 3) == 0) begin
          if (rnd_rel) maybe_rel();
          step();
          rel_vld = 1'b0;
        end
      end
      in_vld         = 1'b1;
      in_sop         = (i == 0);
      in_eop         = (i == act - 1);
      in_data        = {$urandom, $urandom};
      in_des_port    = (i == 0) ? port[3:0] : 4'($urandom);
      in_pack_length = (i == 0) ? decl[6:0] : 7'($urandom);
      if (i == 0 && rel_first > 0) begin
        rel_vld = 1'b1;
        rel_len = rel_first[6:0];
        m_used -= rel_first;
      end else if (rnd_rel) maybe_rel();
      if (i < wlen) begin
        wq.push_back('{addr: m_wr_ptr, data: in_data, stamp: cyc + 1});
        m_wr_ptr = (m_wr_ptr + 1) % 2048;
      end
      if (i == act - 1 && decl > 0) dq.push_back('{port: port, addr: base, len: wlen, stamp: cyc + 1});
      step();
      if (i == 0) used_after_sop = int'(used_words);
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; rel_vld = 1'b0;
    end
    m_used += wlen;
    if (decl == 0 || act != decl) exp_err++;
  endtask

  vec_t tbl[9];

  initial begin
    int d0, e0, u0, n;
    tbl[0] = '{3, 4, 4, 1, 4, 0, 4};
    tbl[1] = '{5, 8, 5, 1, 5, 1, 5};
    tbl[2] = '{2, 3, 6, 1, 3, 1, 3};
    tbl[3] = '{7, 0, 3, 0, 0, 1, 0};
    tbl[4] = '{1, 1, 1, 1, 1, 0, 1};
    tbl[5] = '{9, 0, 1, 0, 0, 1, 0};
    tbl[6] = '{4, 6, 1, 1, 1, 1, 1};
    tbl[7] = '{15, 127, 127, 1, 127, 0, 127};
    tbl[8] = '{6, 1, 3, 1, 1, 1, 1};

    rst = 1'b1; in_vld = 0; in_sop = 0; in_eop = 0; in_data = '0;
    in_des_port = '0; in_pack_length = '0; rel_vld = 0; rel_len = '0;
    repeat (3) step();
    chk(in_rdy == 0 && sram_we == 0 && desc_vld == 0 && err_len == 0 && used_words == 0 && sram_addr == 0,
        "reset_outputs", {in_rdy, sram_we, desc_vld, err_len, used_words}, 64'd0);
    rst = 1'b0;
    step();
    chk(in_rdy == 1'b1, "rdy_after_reset", 64'(in_rdy), 64'd1);

    for (int t = 0; t < 9; t++) begin
      d0 = desc_cnt; e0 = err_seen; u0 = int'(used_words);
      drive_pkt(tbl[t].port, tbl[t].decl, tbl[t].act, 1'b0, 1'b0, 0);
      repeat (3) step();
      chk(desc_cnt - d0 == tbl[t].exp_desc, $sformatf("tbl%0d_desc_cnt", t), 64'(desc_cnt - d0), 64'(tbl[t].exp_desc));
      if (tbl[t].exp_desc != 0)
        chk(last_desc_len == tbl[t].exp_dlen && last_desc_port == tbl[t].port, $sformatf("tbl%0d_desc_len", t),
            64'(last_desc_len), 64'(tbl[t].exp_dlen));
      chk(err_seen - e0 == tbl[t].exp_err, $sformatf("tbl%0d_err", t), 64'(err_seen - e0), 64'(tbl[t].exp_err));
      chk(int'(used_words) - u0 == tbl[t].exp_used, $sformatf("tbl%0d_used", t),
          64'(int'(used_words) - u0), 64'(tbl[t].exp_used));
      if (t == 0)
        chk(desc_we_seen == 1'b1 && desc_waddr_seen == 3, "desc_with_last_write",
            64'(desc_waddr_seen), 64'd3);
    end

    release_all();
    e0 = err_seen;
    rel_vld = 1'b1; rel_len = 7'd5;
    step();
    rel_vld = 1'b0;
    exp_err++;
    step();
    chk(used_words == 0 && err_seen - e0 == 1, "underflow_sat", {used_words, 32'(err_seen - e0)}, 64'd1);

    drive_pkt(2, 50, 50, 1'b0, 1'b0, 0);
    chk(used_words == 50, "used_50", 64'(used_words), 64'd50);
    drive_pkt(8, 20, 20, 1'b0, 1'b0, 10);
    chk(used_after_sop == 60, "rel_with_sop", 64'(used_after_sop), 64'd60);

    while (m_wr_ptr != 2046) begin
      n = 2046 - m_wr_ptr;
      if (n > 127) n = 127;
      drive_pkt(int'($urandom % 16), n, n, 1'b0, 1'b0, 0);
    end
    drive_pkt(5, 5, 5, 1'b0, 1'b0, 0);
    repeat (2) step();
    chk(last_desc_addr == 2046 && last_desc_len == 5, "wrap_desc_addr", 64'(last_desc_addr), 64'd2046);

    release_all();
    for (int k = 0; k < 15; k++) drive_pkt(k, 127, 127, 1'b0, 1'b0, 0);
    drive_pkt(1, 20, 20, 1'b0, 1'b0, 0);
    step();
    chk(in_rdy == 1'b0 && used_words == 1925, "full_not_rdy", {in_rdy, used_words}, {1'b0, 12'd1925});
    e0 = err_seen;
    in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_pack_length = 7'd5; in_data = {$urandom, $urandom};
    step();
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    exp_err++;
    step();
    chk(err_seen - e0 == 1 && used_words == 1925, "sop_not_rdy", 64'(err_seen - e0), 64'd1);
    release_n(64);
    chk(in_rdy == 1'b1 && used_words == 1861, "rdy_after_rel", {in_rdy, used_words}, {1'b1, 12'd1861});

    d0 = desc_cnt;
    in_vld = 1'b1; in_sop = 1'b1; in_pack_length = 7'd10; in_des_port = 4'd2; in_data = {$urandom, $urandom};
    wq.push_back('{addr: m_wr_ptr, data: in_data, stamp: cyc + 1});
    m_wr_ptr = (m_wr_ptr + 1) % 2048;
    step();
    in_sop = 1'b0; in_data = {$urandom, $urandom};
    wq.push_back('{addr: m_wr_ptr, data: in_data, stamp: cyc + 1});
    step();
    in_vld = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk(used_words == 0 && in_rdy == 0 && desc_vld == 0 && sram_we == 0, "mid_pkt_reset",
        {in_rdy, desc_vld, sram_we, used_words}, 64'd0);
    chk(desc_cnt == d0 && wq.size() == 0, "mid_pkt_no_desc", 64'(desc_cnt - d0), 64'd0);
    m_wr_ptr = 0; m_used = 0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk(in_rdy == 1'b1, "rdy_after_mid_reset", 64'(in_rdy), 64'd1);

    for (int p = 0; p < 40; p++) begin
      int decl, act;
      decl = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 24));
      act  = (decl > 0 && ($urandom % 2) == 0) ? decl : int'($urandom_range(1, 26));
      drive_pkt(int'($urandom % 16), decl, act, 1'b1, 1'b1, 0);
      if (p % 8 == 7) chk(int'(used_words) == m_used, "rand_used", 64'(used_words), 64'(m_used));
    end
    repeat (4) step();
    chk(wq.size() == 0 && dq.size() == 0, "queues_drained", 64'(wq.size() + dq.size()), 64'd0);
    chk(err_seen == exp_err, "err_total", 64'(err_seen), 64'(exp_err));
    chk(int'(used_words) == m_used, "final_used", 64'(used_words), 64'(m_used));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
